lagd_fifo_reader: RTL and testbench



---
 rtl/lagd_fifo_reader_pkg.sv | 20 ++
 rtl/lagd_fifo_reader_if.sv | 38 +++
 rtl/lagd_fifo_reader_skid.sv | 58 +++++
 rtl/lagd_fifo_reader.sv | 139 +++++++++++++
 tb/tb_lagd_fifo_reader.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lagd_fifo_reader_pkg.sv
// rtl/lagd_fifo_reader_pkg.sv - shared types and constants for the flip-manager FIFO reader
package lagd_fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } reader_state_e;

  localparam int SKID_DEPTH      = 2;
  localparam int OCC_WIDTH       = $clog2(SKID_DEPTH + 1);
  localparam int STATS_CNT_WIDTH = 32;

  // Saturating increment for the statistics counters.
  function automatic logic [STATS_CNT_WIDTH-1:0] sat_inc(input logic [STATS_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + STATS_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/lagd_fifo_reader_if.sv
// rtl/lagd_fifo_reader_if.sv - FIFO read port and output stream bundle for lagd_fifo_reader
interface lagd_fifo_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_DEPTH = 3
);

  logic                  fifo_empty_i;
  logic [ADDR_DEPTH-1:0] fifo_usage_i;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  fifo_pop_o;
  logic                  fifo_flush_o;
  logic                  out_valid_o;
  logic [DATA_WIDTH-1:0] out_data_o;
  logic                  out_ready_i;

  modport master (
    input  fifo_empty_i,
    input  fifo_usage_i,
    input  fifo_data_i,
    input  out_ready_i,
    output fifo_pop_o,
    output fifo_flush_o,
    output out_valid_o,
    output out_data_o
  );

  modport slave (
    output fifo_empty_i,
    output fifo_usage_i,
    output fifo_data_i,
    output out_ready_i,
    input  fifo_pop_o,
    input  fifo_flush_o,
    input  out_valid_o,
    input  out_data_o
  );

endinterface

// File: rtl/lagd_fifo_reader_skid.sv
// rtl/lagd_fifo_reader_skid.sv - 2-entry valid/ready skid buffer (module lagd_skid_buf)
module lagd_skid_buf
  import lagd_fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [OCC_WIDTH-1:0]  occ_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [OCC_WIDTH-1:0]  occ_q;
  logic                  take;

  assign valid_o = (occ_q != '0);
  assign take    = valid_o & ready_i;
  assign data_o  = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;

  // The caller never pushes into a full buffer, so no overflow guard is needed here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (take) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, take})
        2'b10:   occ_q <= occ_q + OCC_WIDTH'(1);
        2'b01:   occ_q <= occ_q - OCC_WIDTH'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/lagd_fifo_reader.sv
// rtl/lagd_fifo_reader.sv - pop-side FIFO drain controller with skid-buffered output stream
// Optional statistics counters are built when LAGD_FIFO_READER_STATS_EN is defined.
module lagd_fifo_reader
  import lagd_fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [CNT_WIDTH-1:0]       count_i,
  input  logic                       abort_i,
  output logic                       busy_o,
  output logic                       done_o,
`ifdef LAGD_FIFO_READER_STATS_EN
  output logic [STATS_CNT_WIDTH-1:0] stall_cnt_o,
  output logic [STATS_CNT_WIDTH-1:0] underrun_cnt_o,
`endif
  lagd_fifo_reader_if.master         bus
);

  reader_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic                  flush_q;
  logic [OCC_WIDTH-1:0]  occ;
  logic [OCC_WIDTH-1:0]  occ_next;
  logic                  pop;
  logic                  handshake;
  logic                  abort_act;
  logic                  start_acc;
  logic [ADDR_DEPTH-1:0] unused_usage;

  assign unused_usage = bus.fifo_usage_i;

  assign abort_act = abort_i & (state_q != IDLE);
  assign start_acc = start_i & (state_q == IDLE);
  assign handshake = bus.out_valid_o & bus.out_ready_i;

  // Pop gating uses only registered occupancy, keeping out_ready_i off the pop path.
  assign pop = (state_q == READ) & ~abort_i & ~bus.fifo_empty_i &
               (rem_q != '0) & (occ < OCC_WIDTH'(SKID_DEPTH));

  assign occ_next = occ + OCC_WIDTH'(pop) - OCC_WIDTH'(handshake);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (abort_act) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_acc) begin
            if (count_i != '0) begin
              state_d = READ;
              rem_d   = count_i;
            end else begin
              state_d = DONE;
            end
          end
        end
        READ: begin
          if (pop) begin
            rem_d = rem_q - CNT_WIDTH'(1);
            if (rem_q == CNT_WIDTH'(1)) begin
              state_d = DRAIN;
            end
          end
        end
        // Looking at next occupancy lets DONE follow the last handshake directly.
        DRAIN: begin
          if (occ_next == '0) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      flush_q <= abort_act;
    end
  end

  assign busy_o           = (state_q != IDLE);
  assign done_o           = (state_q == DONE);
  assign bus.fifo_pop_o   = pop;
  assign bus.fifo_flush_o = flush_q;

  lagd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (abort_act),
    .push_i  (pop),
    .data_i  (bus.fifo_data_i),
    .occ_o   (occ),
    .valid_o (bus.out_valid_o),
    .ready_i (bus.out_ready_i),
    .data_o  (bus.out_data_o)
  );

`ifdef LAGD_FIFO_READER_STATS_EN
  logic [STATS_CNT_WIDTH-1:0] stall_q;
  logic [STATS_CNT_WIDTH-1:0] underrun_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || start_acc) begin
      stall_q    <= '0;
      underrun_q <= '0;
    end else begin
      if (bus.out_valid_o && !bus.out_ready_i) begin
        stall_q <= sat_inc(stall_q);
      end
      if ((state_q == READ) && bus.fifo_empty_i && (rem_q != '0)) begin
        underrun_q <= sat_inc(underrun_q);
      end
    end
  end

  assign stall_cnt_o    = stall_q;
  assign underrun_cnt_o = underrun_q;
`endif

endmodule

// File: tb/tb_lagd_fifo_reader.sv
// tb/tb_lagd_fifo_reader.sv - scoreboard bench for lagd_fifo_reader
module tb_lagd_fifo_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] count;
  logic        abort;
  logic        busy;
  logic        done;
`ifdef LAGD_FIFO_READER_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] underrun_cnt;
`endif

  lagd_fifo_reader_if #(.DATA_WIDTH(32), .ADDR_DEPTH(3)) bus ();

  lagd_fifo_reader #(
    .DATA_WIDTH (32),
    .DEPTH      (8),
    .CNT_WIDTH  (16)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .count_i        (count),
    .abort_i        (abort),
    .busy_o         (busy),
    .done_o         (done),
`ifdef LAGD_FIFO_READER_STATS_EN
    .stall_cnt_o    (stall_cnt),
    .underrun_cnt_o (underrun_cnt),
`endif
    .bus            (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_q[$];
  logic [31:0] exp_q[$];
  int          exp_cnt = 0;
  int          hs_cnt = 0;
  bit          pop_seen = 0;
  bit          flush_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void refresh();
    bus.fifo_empty_i = (model_q.size() == 0);
    bus.fifo_data_i  = (model_q.size() != 0) ? model_q[0] : 32'h0;
    bus.fifo_usage_i = 3'(model_q.size());
  endfunction

  task automatic push(input logic [31:0] v);
    model_q.push_back(v);
    exp_q.push_back(v);
    refresh();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input int n);
    start   = 1'b1;
    count   = 16'(n);
    exp_cnt = n;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      step();
    end
    chk(name, seen, 1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_pop"},   bus.fifo_pop_o, 0);
    chk({tag, "_flush"}, bus.fifo_flush_o, 0);
    chk({tag, "_valid"}, bus.out_valid_o, 0);
    chk({tag, "_data"},  bus.out_data_o, 0);
  endtask

  // Monitor: every accepted output must be the oldest undelivered FIFO entry.
  always @(negedge clk) begin
    pop_seen   = bus.fifo_pop_o;
    flush_seen = bus.fifo_flush_o;
    if (rst) begin
      hs_cnt = 0;
    end else begin
      if (bus.fifo_pop_o) chk("pop_nonempty", bus.fifo_empty_i, 0);
      if (bus.out_valid_o && bus.out_ready_i) begin
        chk("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("out_data", bus.out_data_o, exp_q.pop_front());
        hs_cnt++;
      end
      if (done) begin
        chk("done_count", hs_cnt, exp_cnt);
        hs_cnt = 0;
      end
      if (bus.fifo_flush_o) hs_cnt = 0;
    end
  end

  // FIFO model: apply pops and flushes seen in the previous cycle.
  always begin
    @(posedge clk);
    #1;
    if (pop_seen && model_q.size() != 0) void'(model_q.pop_front());
    if (flush_seen) begin
      model_q.delete();
      exp_q.delete();
    end
    refresh();
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  n;
    int  pops;
    int  pushed;
    int  hs;
    bit  seen;

    rst = 1'b1; start = 1'b0; count = '0; abort = 1'b0;
    bus.out_ready_i = 1'b0;
    refresh();
    step();
    @(negedge clk);
    check_idle("reset");
    step();
    rst = 1'b0;
    step();

    // Steady stream: five entries, downstream always ready.
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) push(32'h10 + 32'(i));
    start_xfer(5);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("steady_pop_c%0d", c),   bus.fifo_pop_o,  (c <= 5));
      chk($sformatf("steady_valid_c%0d", c), bus.out_valid_o, (c >= 2 && c <= 6));
      chk($sformatf("steady_done_c%0d", c),  done,            (c == 7));
      chk($sformatf("steady_busy_c%0d", c),  busy,            (c < 8));
      step();
    end

    // Zero count completes immediately without popping.
    start_xfer(0);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 1);
    chk("zero_pop",  bus.fifo_pop_o, 0);
    step();
    @(negedge clk);
    chk("zero_idle", busy, 0);
    step();

    // Backpressure: skid fills after two pops and holds its head.
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h10 + 32'(i));
    start_xfer(4);
    pops = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.fifo_pop_o) pops++;
      if (c >= 2) begin
        chk("bp_valid", bus.out_valid_o, 1);
        chk("bp_data",  bus.out_data_o, 32'h10);
      end
      step();
    end
    chk("bp_pops", pops, 2);
`ifdef LAGD_FIFO_READER_STATS_EN
    chk("bp_stall_cnt", stall_cnt, 5);
`endif
    bus.out_ready_i = 1'b1;
    wait_done(30, "bp_done_seen");

    // Underrun: FIFO starts empty and is fed one entry every four cycles.
    start_xfer(3);
    pushed = 0;
    seen   = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (i % 4 == 3 && pushed < 3) begin
        push(32'hA0 + 32'(pushed));
        pushed++;
      end
      @(negedge clk);
      if (done) seen = 1;
      step();
    end
    chk("ur_done_seen", seen, 1);

    // Abort after three handshakes, with entries left in the FIFO and skid.
    for (int i = 0; i < 6; i++) push(32'hB0 + 32'(i));
    start_xfer(8);
    hs = 0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid_o && bus.out_ready_i) hs++;
      if (hs >= 3) seen = 1;
      step();
    end
    chk("ab_reach3", seen, 1);
    bus.out_ready_i = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    chk("ab_cycle_pop", bus.fifo_pop_o, 0);
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("ab_flush", bus.fifo_flush_o, 1);
    chk("ab_valid", bus.out_valid_o, 0);
    chk("ab_busy",  busy, 0);
    chk("ab_done",  done, 0);
    step();
    @(negedge clk);
    chk("ab_flush_once", bus.fifo_flush_o, 0);
    step();
    bus.out_ready_i = 1'b1;
    push(32'hC0);
    push(32'hC1);
    start_xfer(2);
    wait_done(30, "ab_restart_done");

    // Reset in the middle of a READ.
    bus.out_ready_i = 1'b0;
    push(32'hD0);
    push(32'hD1);
    start_xfer(5);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_q.delete();
    exp_q.delete();
    refresh();
    @(negedge clk);
    check_idle("midrst");
    step();

    // start while busy is ignored.
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) push(32'hE0 + 32'(i));
    start_xfer(3);
    step();
    start = 1'b1;
    count = 16'd7;
    step();
    start = 1'b0;
    wait_done(30, "busy_start_done");
    @(negedge clk);
    chk("busy_start_idle", busy, 0);
    step();

    // Randomized transfers with random FIFO arrivals and downstream stalls.
    for (int t = 0; t < 15; t++) begin
      n = $urandom_range(1, 6);
      bus.out_ready_i = 1'($urandom_range(0, 1));
      start_xfer(n);
      seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
        if ($urandom_range(0, 1) == 1 && model_q.size() < 8) push($urandom);
        bus.out_ready_i = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (done) seen = 1;
        step();
      end
      chk($sformatf("rand_done_t%0d", t), seen, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
